// File: rtl/lsu_split_initiator.sv
// RV32I load/store initiator: decodes loads/stores, issues word-aligned memory
// accesses (splitting word-crossing ones in two) and returns extended load data.
module lsu_split_initiator #(
  parameter int MEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] instr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_waddr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        store_q, sign_q, err_q, split_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q, wdata_q, lo_word, hi_word;

  logic        dec_legal, dec_store, dec_sign, dec_err, dec_split;
  logic [2:0]  dec_size;
  logic [32:0] acc_end;
  logic        accept;

  always_comb begin
    dec_legal = 1'b0;
    dec_store = 1'b0;
    dec_sign  = 1'b0;
    dec_size  = 3'd0;
    case (instr[6:0])
      7'b0000011: begin
        case (instr[14:12])
          3'b000:  begin dec_legal = 1'b1; dec_size = 3'd1; dec_sign = 1'b1; end
          3'b001:  begin dec_legal = 1'b1; dec_size = 3'd2; dec_sign = 1'b1; end
          3'b010:  begin dec_legal = 1'b1; dec_size = 3'd4; end
          3'b100:  begin dec_legal = 1'b1; dec_size = 3'd1; end
          3'b101:  begin dec_legal = 1'b1; dec_size = 3'd2; end
          default: ;
        endcase
      end
      7'b0100011: begin
        dec_store = 1'b1;
        case (instr[14:12])
          3'b000:  begin dec_legal = 1'b1; dec_size = 3'd1; end
          3'b001:  begin dec_legal = 1'b1; dec_size = 3'd2; end
          3'b010:  begin dec_legal = 1'b1; dec_size = 3'd4; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // One extra bit so an access running past the top of the address space cannot wrap into range.
  assign acc_end   = {1'b0, addr} + {30'd0, dec_size};
  assign dec_err   = !dec_legal || (acc_end > 33'(MEM_SIZE));
  assign dec_split = ({1'b0, addr[1:0]} + dec_size) > 3'd4;
  assign accept    = req_valid && (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = dec_err ? RESP : ISSUE0;
      ISSUE0:  state_nxt = split_q ? ISSUE1 : WAIT;
      ISSUE1:  state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_word <= '0;
      hi_word <= '0;
    end else begin
      if (accept) begin
        store_q <= dec_store;
        sign_q  <= dec_sign;
        err_q   <= dec_err;
        split_q <= dec_split && !dec_err;
        size_q  <= dec_size;
        addr_q  <= addr;
        wdata_q <= wdata;
        lo_word <= '0;
        hi_word <= '0;
      end
      if (state == ISSUE1) lo_word <= mem_rdata;
      if (state == WAIT) begin
        if (split_q) hi_word <= mem_rdata;
        else begin
          lo_word <= mem_rdata;
          hi_word <= '0;
        end
      end
    end
  end

  logic [3:0]  size_mask;
  logic [7:0]  be_full;
  logic [63:0] wd_full, rd_pair;
  logic [31:0] rd_ext;

  always_comb begin
    case (size_q)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      3'd4:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  // Lanes and data are shifted across a two-word window; each issue cycle takes one half.
  assign be_full = {4'b0000, size_mask} << addr_q[1:0];
  assign wd_full = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
  assign rd_pair = {hi_word, lo_word} >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (size_q)
      3'd1:    rd_ext = sign_q ? {{24{rd_pair[7]}}, rd_pair[7:0]}   : {24'd0, rd_pair[7:0]};
      3'd2:    rd_ext = sign_q ? {{16{rd_pair[15]}}, rd_pair[15:0]} : {16'd0, rd_pair[15:0]};
      default: rd_ext = rd_pair[31:0];
    endcase
  end

  // Outputs decode straight from the state, so an asynchronous reset drops mem_req at once.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    case (state)
      ISSUE0: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_waddr = addr_q[31:2];
        mem_be    = be_full[3:0];
        mem_wdata = wd_full[31:0];
      end
      ISSUE1: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_waddr = addr_q[31:2] + 30'd1;
        mem_be    = be_full[7:4];
        mem_wdata = wd_full[63:32];
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (store_q || err_q) ? 32'd0 : rd_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_split_initiator.sv
// Directed bench for lsu_split_initiator with a fixed-latency word memory model.
module tb_lsu_split_initiator;
  localparam int MEM_SIZE = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] instr, addr, wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [29:0] mem_waddr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  lsu_split_initiator #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .instr(instr), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) if (mem_req) mem_rdata <= mem[mem_waddr[9:0]];

  // Log of every memory request and response seen, sampled on the falling edge.
  int          n_mreq = 0, n_resp = 0;
  logic [31:0] log_waddr [16];
  logic [31:0] log_wdata [16];
  logic [3:0]  log_be    [16];
  logic        log_we    [16];
  always @(negedge clk) begin
    if (mem_req) begin
      log_waddr[n_mreq % 16] = {2'b00, mem_waddr};
      log_wdata[n_mreq % 16] = mem_wdata;
      log_be[n_mreq % 16]    = mem_be;
      log_we[n_mreq % 16]    = mem_we;
      n_mreq++;
    end
    if (resp_valid) n_resp++;
  end

  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld(input logic [2:0] f3);
    return {17'd0, f3, 5'd0, 7'b0000011};
  endfunction
  function automatic logic [31:0] st(input logic [2:0] f3);
    return {17'd0, f3, 5'd0, 7'b0100011};
  endfunction

  int          r_lat, r_base, r_nreq;
  logic [31:0] r_rdata;
  logic        r_err;

  task automatic run_req(input logic [31:0] i, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    r_base    = n_mreq;
    req_valid = 1'b1;
    instr     = i;
    addr      = a;
    wdata     = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    r_lat     = 0;
    r_rdata   = 'x;
    r_err     = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        r_lat   = k;
        r_rdata = resp_rdata;
        r_err   = resp_err;
        break;
      end
    end
    r_nreq = n_mreq - r_base;
    @(negedge clk);
    check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic chk_req(input string tag, input int idx, input logic [31:0] wa,
                         input logic [3:0] be, input logic we);
    check({tag, "_waddr"}, log_waddr[(r_base + idx) % 16], wa);
    check({tag, "_be"}, {28'd0, log_be[(r_base + idx) % 16]}, {28'd0, be});
    check({tag, "_we"}, {31'd0, log_we[(r_base + idx) % 16]}, {31'd0, we});
  endtask

  task automatic chk_resp(input string tag, input int lat, input int nreq,
                          input logic [31:0] rd, input logic err);
    check({tag, "_lat"}, lat, r_lat);
    check({tag, "_nreq"}, r_nreq, nreq);
    check({tag, "_rdata"}, r_rdata, rd);
    check({tag, "_err"}, {31'd0, r_err}, {31'd0, err});
  endtask

  int resp_base;

  initial begin
    rst = 1'b1; req_valid = 1'b0; instr = '0; addr = '0; wdata = '0;
    for (int w = 0; w < 1024; w++) mem[w] = '0;
    #1;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    mem[32'h40] = 32'hDEADBEEF;
    run_req(ld(3'b010), 32'h100, 32'd0);
    chk_resp("lw", 3, 1, 32'hDEADBEEF, 1'b0);
    chk_req("lw", 0, 32'h40, 4'b1111, 1'b0);

    mem[32'h40] = 32'hAB112233;
    mem[32'h41] = 32'h445566CD;
    run_req(ld(3'b001), 32'h103, 32'd0);
    chk_resp("lh_split", 4, 2, 32'hFFFFCDAB, 1'b0);
    chk_req("lh_r0", 0, 32'h40, 4'b1000, 1'b0);
    chk_req("lh_r1", 1, 32'h41, 4'b0001, 1'b0);
    run_req(ld(3'b101), 32'h103, 32'd0);
    chk_resp("lhu_split", 4, 2, 32'h0000CDAB, 1'b0);

    run_req(st(3'b010), 32'h0FE, 32'h12345678);
    chk_resp("sw_split", 4, 2, 32'd0, 1'b0);
    chk_req("sw_r0", 0, 32'h3F, 4'b1100, 1'b1);
    check("sw_r0_wdata", log_wdata[r_base % 16], 32'h56780000);
    chk_req("sw_r1", 1, 32'h40, 4'b0011, 1'b1);
    check("sw_r1_wdata", log_wdata[(r_base + 1) % 16], 32'h00001234);

    mem[32'h40] = 32'h0000F000;
    run_req(ld(3'b000), 32'h101, 32'd0);
    chk_resp("lb", 3, 1, 32'hFFFFFFF0, 1'b0);
    chk_req("lb", 0, 32'h40, 4'b0010, 1'b0);
    run_req(ld(3'b100), 32'h101, 32'd0);
    chk_resp("lbu", 3, 1, 32'h000000F0, 1'b0);

    run_req(st(3'b000), 32'h102, 32'h000000A5);
    chk_resp("sb", 3, 1, 32'd0, 1'b0);
    chk_req("sb", 0, 32'h40, 4'b0100, 1'b1);
    check("sb_wdata", log_wdata[r_base % 16], 32'h00A50000);

    run_req(ld(3'b010), MEM_SIZE - 2, 32'd0);
    chk_resp("lw_oob", 1, 0, 32'd0, 1'b1);
    mem[1023] = 32'h0BADF00D;
    run_req(ld(3'b010), MEM_SIZE - 4, 32'd0);
    chk_resp("lw_top", 3, 1, 32'h0BADF00D, 1'b0);
    run_req(ld(3'b011), 32'h100, 32'd0);
    chk_resp("ld_f3_011", 1, 0, 32'd0, 1'b1);
    run_req(st(3'b100), 32'h100, 32'h1);
    chk_resp("st_f3_100", 1, 0, 32'd0, 1'b1);
    run_req(32'h00000013, 32'h100, 32'd0);
    chk_resp("bad_opcode", 1, 0, 32'd0, 1'b1);

    // Reset in the second issue cycle of a split load aborts it without a response.
    mem[32'h40] = 32'hAB112233;
    @(negedge clk);
    req_valid = 1'b1; instr = ld(3'b001); addr = 32'h103;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("abort_issue0_waddr", {2'b00, mem_waddr}, 32'h40);
    @(posedge clk);
    #1;
    check("abort_issue1_req", {31'd0, mem_req}, 32'd1);
    check("abort_issue1_waddr", {2'b00, mem_waddr}, 32'h41);
    resp_base = n_resp;
    rst = 1'b1;
    #1;
    check("abort_req_drop", {31'd0, mem_req}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_resp", n_resp - resp_base, 32'd0);
    mem[32'h40] = 32'hDEADBEEF;
    run_req(ld(3'b010), 32'h100, 32'd0);
    chk_resp("lw_after_rst", 3, 1, 32'hDEADBEEF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_split_initiator.md
Name: lsu_split_initiator

Overview:
- Load/store initiator between the core execute stage and a word-wide, byte-enabled, fixed-latency data memory.
- Decodes RV32I load/store instructions and issues aligned word accesses to memory.
- Accesses that cross a word boundary are split into two back-to-back word accesses.
- Load data is reassembled, zero- or sign-extended, and returned to the core with a single-cycle response strobe.

Parameters:
MEM_SIZE, 4096, addressable bytes; must be a multiple of 4; accesses outside [0, MEM_SIZE) are errors.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  core request strobe
req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready
instr  in  32  instruction; opcode = instr[6:0], funct3 = instr[14:12]
addr  in  32  effective byte address (rs1 + imm)
wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  load result; 0 for stores and for errors
resp_err  out  1  qualified by resp_valid
mem_req  out  1  memory access strobe
mem_we  out  1  write access when high
mem_waddr  out  30  word address (byte address >> 2)
mem_be  out  4  byte enables, bit i = byte lane i
mem_wdata  out  32  lane-aligned write data
mem_rdata  in  32  read data, valid exactly one cycle after the mem_req cycle

Behaviour:
- Reset: state = IDLE. resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_be and all latched request registers are 0.
- Reset asserted mid-operation aborts immediately: mem_req drops asynchronously and no response is produced for the aborted request.
- Decode:
  - Opcode 0000011 (load), funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Opcode 0100011 (store), funct3: 000 SB, 001 SH, 010 SW.
  - Size n = 1, 2 or 4 bytes. Sign-extend only for LB and LH.
  - Any other opcode or funct3 value is illegal.
- Accept (IDLE, req_valid=1): latch instr fields, addr, wdata. Let o = addr[1:0].
  - Error: illegal decode, or addr + n > MEM_SIZE (computed 33-bit, no wrap). Go to RESP with err = 1. No memory access is made.
  - Split: o + n > 4.
- FSM transitions:
  - IDLE -> ISSUE0 (legal request) or RESP (error).
  - ISSUE0 -> ISSUE1 (split) or WAIT (not split).
  - ISSUE1 -> WAIT.
  - WAIT -> RESP.
  - RESP -> IDLE.
- ISSUE0 outputs:
  - mem_req = 1, mem_waddr = addr[31:2], mem_we = store.
  - mem_be = (((1<<n)-1) << o)[3:0].
  - mem_wdata = wdata << 8·o.
- ISSUE1 outputs:
  - mem_req = 1, mem_waddr = addr[31:2] + 1.
  - mem_be = (((1<<n)-1) << o) >> 4.
  - mem_wdata = wdata >> 8·(4−o).
  - Capture mem_rdata as lo_word.
- WAIT: mem_req = 0. Capture mem_rdata as the last word.
  - Not split: lo_word = captured word, hi_word = 0.
  - Split: hi_word = captured word.
- RESP: resp_valid = 1 for exactly one cycle.
  - Load: resp_rdata = low n bytes of ({hi_word, lo_word} >> 8·o), extended to 32 bits.
  - Store or error: resp_rdata = 0.
- Latency from the acceptance edge to the resp_valid cycle:
  - Aligned / non-split: 3 cycles.
  - Split: 4 cycles.
  - Error: 1 cycle.
- Throughput: req_ready is low outside IDLE, so the next request can be accepted in the cycle after RESP. Requests presented outside IDLE are not accepted and must be held by the core.
- mem_rdata is ignored for stores. Memory outputs (mem_req, mem_we, mem_be, mem_wdata, mem_waddr) are 0 in IDLE, RESP and WAIT.

Test Plan:
- LW at 0x100, memory word 0x100 = 0xDEADBEEF -> one mem_req, waddr 0x40, be 1111; 3 cycles later resp_rdata = 0xDEADBEEF, err = 0.
- LH at 0x103, word 0x100 = 0xAB112233, word 0x104 = 0x445566CD -> two requests (waddr 0x40 be 1000, waddr 0x41 be 0001); resp_rdata = 0xFFFFCDAB. The same access as LHU returns 0x0000CDAB.
- SW 0x12345678 at 0x0FE -> first request waddr 0x3F be 1100 wdata 0x56780000; second request waddr 0x40 be 0011 wdata 0x00001234; resp_rdata = 0, err = 0.
- LB at 0x101 with word 0x100 = 0x0000F000 -> be 0010; resp_rdata = 0xFFFFFFF0. SB 0xA5 at 0x102 -> be 0100, wdata 0x00A50000.
- Out of bounds and illegal decode:
  - LW at MEM_SIZE−2 -> no mem_req; resp_valid with err = 1, resp_rdata = 0, on the cycle after acceptance.
  - funct3 = 011 on the load opcode -> same error response.
- Assert rst during ISSUE1 of a split load -> mem_req drops in the same cycle and no resp_valid is produced. After release, req_ready = 1 and the next aligned LW completes normally.
